// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO controller: register map, bit indices, TX FSM encoding.
package uart_pkg;

    localparam logic [15:0] DEFAULT_BAUD_DIV = 16'd521;
    localparam logic [15:0] MIN_BAUD_DIV     = 16'd16;

    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_RXDATA = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'hC;

    localparam int unsigned ST_RX_FULL  = 0;
    localparam int unsigned ST_TX_FULL  = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_TX_BUSY  = 3;
    localparam int unsigned ST_RX_OVR   = 4;
    localparam int unsigned ST_PAR_ERR  = 5;
    localparam int unsigned ST_TX_OVF   = 6;

    localparam int unsigned CTRL_PARITY_EN = 16;
    localparam int unsigned CTRL_RX_IE     = 17;
    localparam int unsigned CTRL_TX_IE     = 18;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE      = 2'd0;
    localparam tx_state_t TX_START     = 2'd1;
    localparam tx_state_t TX_WAIT_BUSY = 2'd2;
    localparam tx_state_t TX_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped register front end for a UART: TX byte queue and launch FSM, RX holding
// register, sticky error flags, baud/parity control and a registered interrupt.
module uart_mmio_ctrl #(
    parameter int unsigned TX_FIFO_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_BAUD_DIV = uart_pkg::DEFAULT_BAUD_DIV
) (
    input  logic        clk_50Mhz,
    input  logic        rst_n,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_parity_err,
    output logic [15:0] baud_div,
    output logic        parity_en,
    output logic        irq
);

    import uart_pkg::*;

    logic [3:0]  reg_off;
    logic        wr_tx, wr_status, wr_ctrl, rd_rx;
    logic        fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [$clog2(TX_FIFO_DEPTH):0] fifo_count;
    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, rx_byte_q;
    logic        rx_full_q, rx_ovr_q, par_err_q, tx_ovf_q;
    logic [15:0] baud_div_q;
    logic        parity_en_q, rx_ie_q, tx_ie_q, irq_q;
    logic        rx_ovr_set, par_err_set, tx_ovf_set;
    logic [31:0] status, ctrl;
    logic        unused;

    assign reg_off   = {bus_addr[3:2], 2'b00};
    assign wr_tx     = bus_we & (reg_off == REG_TXDATA);
    assign wr_status = bus_we & (reg_off == REG_STATUS);
    assign wr_ctrl   = bus_we & (reg_off == REG_CTRL);
    assign rd_rx     = bus_re & (reg_off == REG_RXDATA);
    assign unused    = ^{bus_addr[1:0], bus_wdata[31:19], fifo_count};

    assign fifo_pop  = (state_q == TX_IDLE) & ~fifo_empty & ~tx_busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_50Mhz),
        .rst_n (rst_n),
        .push  (wr_tx),
        .wdata (bus_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TX_IDLE:      if (fifo_pop) state_d = TX_START;
            TX_START:     state_d = TX_WAIT_BUSY;
            TX_WAIT_BUSY: if (tx_busy) state_d = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) state_d = TX_IDLE;
            default:      state_d = TX_IDLE;
        endcase
    end

    // Set events take priority over a W1C clear landing in the same cycle.
    assign rx_ovr_set  = rx_valid & rx_full_q & ~rd_rx;
    assign par_err_set = rx_valid & rx_parity_err & parity_en_q;
    assign tx_ovf_set  = wr_tx & fifo_full & ~fifo_pop;

    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TX_IDLE;
            tx_data_q   <= '0;
            rx_byte_q   <= '0;
            rx_full_q   <= 1'b0;
            rx_ovr_q    <= 1'b0;
            par_err_q   <= 1'b0;
            tx_ovf_q    <= 1'b0;
            baud_div_q  <= DEFAULT_BAUD_DIV;
            parity_en_q <= 1'b1;
            rx_ie_q     <= 1'b0;
            tx_ie_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) tx_data_q <= fifo_rdata;

            if (rx_valid && (!rx_full_q || rd_rx)) begin
                rx_byte_q <= rx_data;
                rx_full_q <= 1'b1;
            end else if (rd_rx) begin
                rx_full_q <= 1'b0;
            end

            if (rx_ovr_set)                          rx_ovr_q  <= 1'b1;
            else if (wr_status && bus_wdata[ST_RX_OVR])  rx_ovr_q  <= 1'b0;
            if (par_err_set)                         par_err_q <= 1'b1;
            else if (wr_status && bus_wdata[ST_PAR_ERR]) par_err_q <= 1'b0;
            if (tx_ovf_set)                          tx_ovf_q  <= 1'b1;
            else if (wr_status && bus_wdata[ST_TX_OVF])  tx_ovf_q  <= 1'b0;

            if (wr_ctrl) begin
                baud_div_q  <= (bus_wdata[15:0] < MIN_BAUD_DIV) ? MIN_BAUD_DIV : bus_wdata[15:0];
                parity_en_q <= bus_wdata[CTRL_PARITY_EN];
                rx_ie_q     <= bus_wdata[CTRL_RX_IE];
                tx_ie_q     <= bus_wdata[CTRL_TX_IE];
            end

            irq_q <= (rx_ie_q & rx_full_q) | (tx_ie_q & fifo_empty & (state_q == TX_IDLE));
        end
    end

    always_comb begin
        status              = '0;
        status[ST_RX_FULL]  = rx_full_q;
        status[ST_TX_FULL]  = fifo_full;
        status[ST_TX_EMPTY] = fifo_empty;
        status[ST_TX_BUSY]  = (state_q != TX_IDLE);
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_PAR_ERR]  = par_err_q;
        status[ST_TX_OVF]   = tx_ovf_q;
    end

    assign ctrl = {13'b0, tx_ie_q, rx_ie_q, parity_en_q, baud_div_q};

    always_comb begin
        bus_rdata = '0;
        unique case (reg_off)
            REG_RXDATA: bus_rdata = {24'b0, rx_byte_q};
            REG_STATUS: bus_rdata = status;
            REG_CTRL:   bus_rdata = ctrl;
            default:    bus_rdata = '0;
        endcase
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = (state_q == TX_START);
    assign baud_div  = baud_div_q;
    assign parity_en = parity_en_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: drivers queue expected reads and TX bytes, a negedge
// monitor pops and compares them; a small transmitter model answers tx_start with tx_busy.
module tb_uart_mmio_ctrl;

    logic        clk_50Mhz = 1'b0;
    logic        rst_n = 1'b1;
    logic        bus_we = 1'b0, bus_re = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0, rx_parity_err = 1'b0;
    logic [15:0] baud_div;
    logic        parity_en, irq;

    logic        model_busy = 1'b0, force_busy = 1'b0, model_en = 1'b0;
    assign tx_busy = model_busy | force_busy;

    int          n_vec = 0, n_err = 0, tx_count = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];

    always #10 clk_50Mhz = ~clk_50Mhz;

    uart_mmio_ctrl dut (
        .clk_50Mhz     (clk_50Mhz),
        .rst_n         (rst_n),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .baud_div      (baud_div),
        .parity_en     (parity_en),
        .irq           (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every load and every tx_start is matched against the scoreboard queues.
    initial forever begin
        @(negedge clk_50Mhz);
        if (bus_re) begin
            if (rd_q.size() == 0) check("rd_sb_underflow", 32'(rd_q.size()), 32'd1);
            else check("bus_rdata", bus_rdata, rd_q.pop_front());
        end
        if (tx_start) begin
            tx_count++;
            if (tx_q.size() == 0) check("tx_sb_underflow", 32'(tx_q.size()), 32'd1);
            else check("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        end
    end

    // Transmitter model: busy for 5 cycles after each start pulse.
    initial forever begin
        @(negedge clk_50Mhz);
        if (tx_start && model_en) begin
            model_busy = 1'b1;
            repeat (5) @(negedge clk_50Mhz);
            model_busy = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_50Mhz);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk_50Mhz); #1;
        bus_we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus_re = 1'b1; bus_addr = a;
        @(posedge clk_50Mhz); #1;
        bus_re = 1'b0;
    endtask

    task automatic rx(input logic [7:0] d, input logic pe);
        rx_valid = 1'b1; rx_data = d; rx_parity_err = pe;
        @(posedge clk_50Mhz); #1;
        rx_valid = 1'b0; rx_parity_err = 1'b0;
    endtask

    task automatic rx_with_read(input logic [7:0] d, input logic [31:0] exp);
        rd_q.push_back(exp);
        bus_re = 1'b1; bus_addr = 4'h4;
        rx_valid = 1'b1; rx_data = d;
        @(posedge clk_50Mhz); #1;
        bus_re = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_count < n && k < budget) begin
            @(posedge clk_50Mhz);
            k++;
        end
        #1;
        check("tx_count", 32'(tx_count), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"}, {31'b0, tx_start}, 32'd0);
        check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
        check({tag, "_irq"}, {31'b0, irq}, 32'd0);
        check({tag, "_baud_div"}, {16'b0, baud_div}, 32'd521);
        check({tag, "_parity_en"}, {31'b0, parity_en}, 32'd1);
    endtask

    initial begin
        int saved;
        #5 rst_n = 1'b0;
        #5 check_reset_outputs("reset");
        repeat (2) @(posedge clk_50Mhz);
        #1 rst_n = 1'b1;
        idle(1);
        rd(4'hC, 32'h0001_0209);
        rd(4'h8, 32'h0000_0004);
        rd(4'h4, 32'h0000_0000);

        // Four bytes through a busy-for-5 transmitter, first start two cycles after the write.
        model_en = 1'b1;
        for (int i = 1; i <= 4; i++) tx_q.push_back(8'(i));
        wr(4'h0, 32'h01);
        @(negedge clk_50Mhz) check("tx_start_lat1", {31'b0, tx_start}, 32'd0);
        @(negedge clk_50Mhz) check("tx_start_lat2", {31'b0, tx_start}, 32'd1);
        @(posedge clk_50Mhz); #1;
        for (int i = 2; i <= 4; i++) wr(4'h0, 32'(i));
        wait_tx(4, 200);
        idle(10);
        rd(4'h8, 32'h0000_0004);

        // Overflow with the transmitter stuck busy, then W1C of tx_ovf and drain.
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) wr(4'h0, 32'h10 + 32'(i));
        rd(4'h8, 32'h0000_0042);
        wr(4'h8, 32'h40);
        rd(4'h8, 32'h0000_0002);
        for (int i = 0; i < 4; i++) tx_q.push_back(8'h10 + 8'(i));
        force_busy = 1'b0;
        wait_tx(8, 300);
        idle(10);
        rd(4'h8, 32'h0000_0004);

        // RX overrun: second byte dropped.
        rx(8'h01, 1'b0);
        rx(8'h02, 1'b0);
        rd(4'h8, 32'h0000_0015);
        rd(4'h4, 32'h0000_0001);
        rd(4'h8, 32'h0000_0014);
        wr(4'h8, 32'h10);
        rd(4'h8, 32'h0000_0004);

        // New byte arriving on the read edge replaces the old one without overrun.
        rx(8'h01, 1'b0);
        rx_with_read(8'h03, 32'h0000_0001);
        rd(4'h4, 32'h0000_0003);
        rd(4'h8, 32'h0000_0004);

        // Parity error flagged only with parity enabled; byte kept either way.
        rx(8'h04, 1'b1);
        rd(4'h8, 32'h0000_0025);
        rd(4'h4, 32'h0000_0004);
        wr(4'h8, 32'h20);
        rd(4'h8, 32'h0000_0004);
        wr(4'hC, 32'h0000_0209);
        rd(4'hC, 32'h0000_0209);
        check("parity_en_off", {31'b0, parity_en}, 32'd0);
        rx(8'h04, 1'b1);
        rd(4'h8, 32'h0000_0005);
        rd(4'h4, 32'h0000_0004);
        wr(4'hC, 32'h0000_0005);
        rd(4'hC, 32'h0000_0010);
        check("baud_clamp", {16'b0, baud_div}, 32'd16);

        // Interrupt sources with one cycle of registration latency.
        wr(4'hC, 32'h0005_0209);
        check("irq_tx_lat", {31'b0, irq}, 32'd0);
        idle(1);
        check("irq_tx", {31'b0, irq}, 32'd1);
        wr(4'hC, 32'h0003_0209);
        check("irq_tx_hold", {31'b0, irq}, 32'd1);
        idle(1);
        check("irq_tx_off", {31'b0, irq}, 32'd0);
        rx(8'h55, 1'b0);
        check("irq_rx_lat", {31'b0, irq}, 32'd0);
        idle(1);
        check("irq_rx", {31'b0, irq}, 32'd1);
        rd(4'h4, 32'h0000_0055);
        check("irq_rx_hold", {31'b0, irq}, 32'd1);
        idle(1);
        check("irq_rx_off", {31'b0, irq}, 32'd0);

        // Reset mid-frame with two bytes still queued.
        wr(4'hC, 32'h0000_0100);
        rd(4'hC, 32'h0000_0100);
        tx_q.push_back(8'h21);
        wr(4'h0, 32'h21);
        wr(4'h0, 32'h22);
        wr(4'h0, 32'h23);
        wait_tx(9, 50);
        idle(2);
        check("pre_reset_busy", {31'b0, tx_busy}, 32'd1);
        saved = tx_count;
        rst_n = 1'b0;
        #1 check_reset_outputs("midframe");
        idle(2);
        rst_n = 1'b1;
        idle(30);
        check("no_tx_after_reset", 32'(tx_count), 32'(saved));
        rd(4'hC, 32'h0001_0209);
        rd(4'h8, 32'h0000_0004);

        idle(2);
        check("rd_sb_left", 32'(rd_q.size()), 32'd0);
        check("tx_sb_left", 32'(tx_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
